mux5_in_1: RTL and testbench
============================

Name: mux5_in_1

Overview:
- Registered 5-way data selector/combiner for two 8-bit operands.
- A 3-bit control code selects one of five functions of data_a/data_b; the result is captured on the rising clock edge and driven on o_data.
- Small datapath leaf used wherever a run-time selectable operand or simple ALU-style result is needed.

Parameters:
- WIDTH, 8, bit width of data_a, data_b and o_data.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  reset; asynchronous assert and clear of all state.
- i_cntr  input  3  function select code.
- data_a  input  WIDTH  operand A.
- data_b  input  WIDTH  operand B.
- o_data  output  WIDTH  registered result.

Behaviour:
- Interface: one clock, i_clk; reset is asynchronous and active-high, named i_reset.
- Reset:
  - i_reset=1 forces o_data=0 immediately, with no clock edge needed, and holds it at 0 while asserted.
  - On release, the first rising i_clk edge with i_reset=0 loads a new result.
- Function select is combinational from i_cntr, data_a and data_b, sampled at the rising edge:
  - 0: o_data <= data_a
  - 1: o_data <= data_b
  - 2: o_data <= (data_a + data_b) mod 2^WIDTH; carry discarded
  - 3: o_data <= (data_a - data_b) mod 2^WIDTH; two's-complement wrap, borrow discarded
  - 4: o_data <= data_a & data_b (bitwise AND)
  - 5, 6, 7: unused codes; o_data holds its previous value and the register is not updated.
- Latency:
  - Exactly one clock. The result for inputs present before rising edge N appears after edge N.
  - The output is stable between edges; no combinational path from inputs to o_data.
- Inputs changing between edges have no effect until the next rising edge.
- i_cntr may change every cycle; each edge uses the code present at that edge.
- Reset mid-operation: o_data goes to 0 asynchronously regardless of i_cntr. A held-value state (codes 5-7) is also cleared to 0.
- If a clock edge coincides with reset asserted, reset wins and o_data=0.
- Arithmetic width: all operations are WIDTH bits, unsigned; no status flags are produced.
- No X propagation from unused codes: o_data is always a defined value after reset.

Test Plan:
- Reset: drive data_a=5, data_b=2, i_cntr=0, assert i_reset between clock edges -> o_data=0 immediately; it stays 0 across edges while reset is high.
- Pass-through: release reset, data_a=8'h3C, data_b=8'hA5; i_cntr=0 then 1 on successive edges -> o_data=8'h3C after the first edge, 8'hA5 after the second.
- Add wrap: i_cntr=2, data_a=8'hF0, data_b=8'h20 -> o_data=8'h10 after one edge. With data_a=3, data_b=4 -> o_data=7.
- Subtract wrap: i_cntr=3, data_a=2, data_b=6 -> o_data=8'hFC. With data_a=10, data_b=4 -> o_data=6.
- AND and unused codes:
  - i_cntr=4, data_a=8'hCC, data_b=8'hAA -> o_data=8'h88.
  - Then i_cntr=5/6/7 with changing data -> o_data stays 8'h88.
  - Asserting i_reset during this hold -> o_data=0.
- Sweep: counter-driven i_cntr 0..7 with data_a incrementing and data_b incrementing by 2 -> each edge's o_data matches the function table one cycle late; no X after reset.

Source files
------------

// File: rtl/mux5_in_1.sv
// ---------------------------------------------------------------------------
// mux5_in_1
//
// Registered 5-way selector/combiner for two unsigned operands. A 3-bit code
// picks one function of data_a/data_b. The result is captured on the rising
// edge of i_clk and driven on o_data, so the latency is exactly one clock.
//
//   code 0 : data_a
//   code 1 : data_b
//   code 2 : data_a + data_b   (WIDTH bits, carry dropped)
//   code 3 : data_a - data_b   (WIDTH bits, two's-complement wrap)
//   code 4 : data_a & data_b
//   code 5-7 : o_data keeps its previous value
//
// There is no handshake: every rising edge with i_reset low takes a new
// sample of i_cntr, data_a and data_b.
//
// Ports:
//   i_clk   in   1      clock, rising edge active
//   i_reset in   1      asynchronous active-high reset, clears o_data to 0
//   i_cntr  in   3      function select code
//   data_a  in   WIDTH  operand A
//   data_b  in   WIDTH  operand B
//   o_data  out  WIDTH  registered result
// ---------------------------------------------------------------------------
module mux5_in_1 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [2:0]       i_cntr,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] o_data_d;
    logic [WIDTH-1:0] o_data_q;

    // Next-state selection. Unused codes feed the current value back so the
    // register simply holds; this keeps o_data free of X after reset.
    always_comb begin
        o_data_d = o_data_q;
        case (i_cntr)
            3'd0:    o_data_d = data_a;
            3'd1:    o_data_d = data_b;
            3'd2:    o_data_d = data_a + data_b;
            3'd3:    o_data_d = data_a - data_b;
            3'd4:    o_data_d = data_a & data_b;
            default: o_data_d = o_data_q;
        endcase
    end

    // Reset takes priority over a coincident clock edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data_q <= '0;
        end else begin
            o_data_q <= o_data_d;
        end
    end

    // Output comes straight from the flop: no combinational input path.
    assign o_data = o_data_q;

endmodule

// File: tb/tb_mux5_in_1.sv
// ---------------------------------------------------------------------------
// tb_mux5_in_1
//
// Directed bench for mux5_in_1. Inputs are driven 1 ns after the rising
// edge; o_data is sampled 1 ns after the rising edge as well, i.e. after the
// flop has updated and well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mux5_in_1;

    localparam int W = 8;

    logic         i_clk;
    logic         i_reset;
    logic [2:0]   i_cntr;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] o_data;

    int tests_run;
    int tests_failed;

    logic [W-1:0] exp_q[$];

    mux5_in_1 #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_cntr  (i_cntr),
        .data_a  (data_a),
        .data_b  (data_b),
        .o_data  (o_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        i_cntr = c;
        data_a = a;
        data_b = b;
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] expected);
        tests_run++;
        assert (o_data === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: o_data=%h expected=%h", tag, o_data, expected);
        end
    endtask

    // Reference function table for the sweep, written from the code table.
    function automatic logic [W-1:0] ref_fn(input logic [2:0] c,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] prev);
        case (c)
            3'd0:    return a;
            3'd1:    return b;
            3'd2:    return W'(a + b);
            3'd3:    return W'(a - b);
            3'd4:    return a & b;
            default: return prev;
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] a_v;
        logic [W-1:0] b_v;
        tests_run    = 0;
        tests_failed = 0;
        i_reset      = 1'b0;
        drive(3'd0, 8'd5, 8'd2);

        // Load a non-zero value first so the async clear is visible.
        step();
        check("pre_reset_load", 8'd5);

        // Assert reset between edges: o_data clears with no clock edge.
        i_reset = 1'b1;
        #2;
        check("reset_async", 8'h00);
        step();
        check("reset_hold_edge1", 8'h00);
        step();
        check("reset_hold_edge2", 8'h00);

        // Release and pass-through.
        i_reset = 1'b0;
        drive(3'd0, 8'h3C, 8'hA5);
        step();
        check("pass_a", 8'h3C);
        drive(3'd1, 8'h3C, 8'hA5);
        step();
        check("pass_b", 8'hA5);

        // Inputs changing between edges must not reach o_data.
        drive(3'd0, 8'h77, 8'h11);
        #2;
        check("no_comb_path", 8'hA5);
        step();
        check("mid_change_load", 8'h77);

        // Add with carry dropped.
        drive(3'd2, 8'hF0, 8'h20);
        step();
        check("add_wrap", 8'h10);
        drive(3'd2, 8'd3, 8'd4);
        step();
        check("add_small", 8'd7);

        // Subtract with wrap.
        drive(3'd3, 8'd2, 8'd6);
        step();
        check("sub_wrap", 8'hFC);
        drive(3'd3, 8'd10, 8'd4);
        step();
        check("sub_small", 8'd6);

        // AND, then hold on unused codes.
        drive(3'd4, 8'hCC, 8'hAA);
        step();
        check("and", 8'h88);
        drive(3'd5, 8'h11, 8'h22);
        step();
        check("hold_code5", 8'h88);
        drive(3'd6, 8'h33, 8'h44);
        step();
        check("hold_code6", 8'h88);
        drive(3'd7, 8'h55, 8'h66);
        step();
        check("hold_code7", 8'h88);

        // Reset during hold clears it; an edge while reset is high stays 0.
        i_reset = 1'b1;
        #2;
        check("reset_during_hold", 8'h00);
        drive(3'd0, 8'h5A, 8'h00);
        step();
        check("reset_wins_edge", 8'h00);

        // After release, an unused code holds the cleared value.
        i_reset = 1'b0;
        drive(3'd7, 8'hEE, 8'hDD);
        step();
        check("hold_after_reset", 8'h00);

        // Sweep: codes 0..7, a increments by 1, b by 2. Expected values go
        // into the scoreboard queue and are popped one edge later.
        prev = 8'h00;
        a_v  = 8'hF8;
        b_v  = 8'h03;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), a_v, b_v);
            prev = ref_fn(3'(i), a_v, b_v, prev);
            exp_q.push_back(prev);
            step();
            check($sformatf("sweep_code%0d", i), exp_q.pop_front());
            a_v = a_v + 8'd1;
            b_v = b_v + 8'd2;
        end

        // Final report.
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
